lmsm_sequencer: RTL

Multicycle control block that sequences Load-Multiple / Store-Multiple (LM/SM) instructions. It captures the 8-bit register-list immediate and the base address, then walks set bits lowest-first. Each set bit issues one memory word transfer and one register-file access. It sits between the main control FSM, the memory interface and the register file.

---
 rtl/lmsm_pkg.sv | 14 +
 rtl/priority_encoder.sv | 14 +
 rtl/lmsm_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/lmsm_pkg.sv
// Shared types and defaults for the LM/SM sequencer.
package lmsm_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int LIST_W_DEF = 8;
    localparam int REG_IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/priority_encoder.sv
// Index of the lowest set bit of an 8-bit vector; output for all-zero input is 0.
module priority_encoder (
    input  logic [7:0] imm8,
    output logic [2:0] firstOnePosition
);

    always_comb begin
        firstOnePosition = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (imm8[i]) firstOnePosition = 3'(i);
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks the register list lowest-first, one memory word per set bit.
// Optional base-register writeback is enabled by defining LMSM_BASE_WRITEBACK_EN.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on start
// ACCESS | one transfer per set mask bit, held until mem_ready
// DONE   | one-cycle completion pulse (and optional base writeback)
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LIST_W = LIST_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_store,
    input  logic [LIST_W-1:0]    imm8,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 mem_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [REG_IDX_W-1:0] reg_addr,
    output logic                 rf_wr,
    output logic                 base_wr,
    output logic [ADDR_W-1:0]    base_wr_data,
    output logic                 busy,
    output logic                 done
);

    state_t                 state_q;
    state_t                 state_d;
    logic [LIST_W-1:0]      mask_q;
    logic [LIST_W-1:0]      mask_clr;
    logic [ADDR_W-1:0]      addr_q;
    logic                   store_q;
    logic [REG_IDX_W-1:0]   low_idx;

    priority_encoder u_penc (
        .imm8             (mask_q),
        .firstOnePosition (low_idx)
    );

    always_comb begin
        mask_clr          = mask_q;
        mask_clr[low_idx] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = (imm8 != '0) ? ACCESS : DONE;
            end
            ACCESS: begin
                if (mem_ready && (mask_clr == '0)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are latched only on an accepted start, so later input changes are invisible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q  <= '0;
            addr_q  <= '0;
            store_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            mask_q  <= imm8;
            addr_q  <= base_addr;
            store_q <= is_store;
        end else if ((state_q == ACCESS) && mem_ready) begin
            mask_q  <= mask_clr;
            addr_q  <= addr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        mem_addr     = '0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        reg_addr     = '0;
        rf_wr        = 1'b0;
        base_wr      = 1'b0;
        base_wr_data = '0;
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        case (state_q)
            ACCESS: begin
                mem_addr = addr_q;
                reg_addr = low_idx;
                mem_rd   = ~store_q;
                mem_wr   = store_q;
                rf_wr    = ~store_q & mem_ready;
            end
            DONE: begin
`ifdef LMSM_BASE_WRITEBACK_EN
                // addr has advanced once per transfer, so it already holds base+N.
                base_wr      = 1'b1;
                base_wr_data = addr_q;
`else
                base_wr      = 1'b0;
                base_wr_data = '0;
`endif
            end
            default: ;
        endcase
    end

endmodule
